// File: rtl/mux_pkg.sv
// Shared constants, types and helpers for the N:1 stream multiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

    // Largest channel count the mux is intended to be built with.
    localparam int MAX_N = 16;

    // Arbitration mode, mirrors the integer RR parameter of the mux.
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Width of a channel index; never narrower than one bit so N=1 still has a port.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Combinational N-way arbiter: round-robin after ptr, or lowest index first.
// Latency: zero (purely combinational, pointer storage lives in the parent).
// Backpressure: en=0 forces gnt to zero; gnt_idx/any_req still reflect req.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int RR = 1,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_req
);

    localparam arb_mode_e MODE = (RR != 0) ? ARB_RR : ARB_FIXED;

    int w_dist;
    int w_best_d;
    int w_best_i;

    // Pick the requester closest to the search start: ptr+1 in RR mode, 0 in fixed mode.
    always_comb begin
        w_dist   = 0;
        w_best_d = N;
        w_best_i = 0;
        for (int i = 0; i < N; i++) begin
            if (MODE == ARB_RR) begin
                // Distance from ptr+1 going upward with wrap; offset keeps it non-negative.
                w_dist = (i - int'(ptr) - 1 + 2 * N) % N;
            end else begin
                w_dist = i;
            end
            if (req[i] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_best_i = i;
            end
        end
    end

    // One-hot grant, suppressed when the consumer cannot take a word this cycle.
    always_comb begin
        any_req = |req;
        gnt_idx = SEL_W'(w_best_i);
        gnt     = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = en && any_req && (w_best_i == i);
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 stream mux: arbitrates N valid/ready producers into one registered output stage.
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle with out_ready high.
// Backpressure: out_valid && !out_ready freezes the output and drops every in_ready.
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 1,
    localparam int SEL_W = sel_width(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0][WIDTH-1:0] in_data,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam arb_mode_e MODE = (RR != 0) ? ARB_RR : ARB_FIXED;

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    logic             w_load;
    logic             w_arb_en;
    logic [N-1:0]     w_gnt;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_any;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    // Output stage can take a word when empty or when its current word leaves this cycle.
    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign w_load   = !r_out_valid || out_ready;
    assign w_arb_en = w_load && rst_n;

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_req (w_any)
    );

    assign in_ready = w_gnt;
    // A grant is only issued to a valid channel, so any grant bit is a handshake.
    assign w_xfer   = |w_gnt;

    // AND-OR select of the granted word; avoids an index that is wider than the array for N=1.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = w_sel_data | in_data[i];
            end
        end
    end

    // Output register: load on handshake, empty on an idle load cycle, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer remembers the last winner; it only moves on a real transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SEL_W'(N - 1);
        end else if (w_xfer && (MODE == ARB_RR)) begin
            r_ptr <= w_gnt_idx;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

    // At most one producer is ever offered the output stage.
    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    // A word waiting on the consumer must not change underneath it.
    a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel) && out_valid));

endmodule

// File: tb/tb_mux_nx1_stream.sv
module tb_mux_nx1_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0;
    logic [3:0][31:0]     in_data;
    logic [3:0]           in_valid;
    logic                 out_ready;

    logic [3:0]  rr_in_ready, fx_in_ready;
    logic [31:0] rr_out_data, fx_out_data, n1_out_data;
    logic [1:0]  rr_out_sel, fx_out_sel;
    logic [0:0]  n1_out_sel, n1_in_ready;
    logic        rr_out_valid, fx_out_valid, n1_out_valid;

    mux_nx1_stream #(.WIDTH(32), .N(4), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_valid(rr_out_valid), .out_ready(out_ready));

    mux_nx1_stream #(.WIDTH(32), .N(4), .RR(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fx_in_ready), .out_data(fx_out_data), .out_sel(fx_out_sel),
        .out_valid(fx_out_valid), .out_ready(out_ready));

    mux_nx1_stream #(.WIDTH(32), .N(1), .RR(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(n1_in_ready), .out_data(n1_out_data), .out_sel(n1_out_sel),
        .out_valid(n1_out_valid), .out_ready(out_ready));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: index 0=RR N=4, 1=fixed N=4, 2=RR N=1
    int          m_n  [3] = '{4, 4, 1};
    bit          m_rr [3] = '{1'b1, 1'b0, 1'b1};
    bit          m_v  [3] = '{0, 0, 0};
    logic [31:0] m_d  [3] = '{0, 0, 0};
    int          m_s  [3] = '{0, 0, 0};
    int          m_p  [3] = '{3, 3, 0};

    // Winner by the stated rule: scan ptr+1, ptr+2, ... (mod n) or 0,1,... ; -1 if none.
    function automatic int pick(input int n, input bit rr, input int p, input logic [3:0] v);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = rr ? (p + 1 + k) % n : k;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(input int i);
        int g;
        g = pick(m_n[i], m_rr[i], m_p[i], in_valid);
        if (rst_n && (!m_v[i] || out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 0; m_d[i] = '0; m_s[i] = 0; m_p[i] = m_n[i] - 1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_v[i] || out_ready) begin
                    int g;
                    g = pick(m_n[i], m_rr[i], m_p[i], in_valid);
                    if (g >= 0) begin
                        m_v[i] = 1; m_d[i] = in_data[g]; m_s[i] = g;
                        if (m_rr[i]) m_p[i] = g;
                    end else begin
                        m_v[i] = 0;
                    end
                end
            end
        end
    end

    // Every cycle: all outputs of all three instances against the model.
    always @(negedge clk) begin
        chk("rr_valid", 32'(rr_out_valid), 32'(m_v[0]));
        chk("rr_data",  rr_out_data,       m_d[0]);
        chk("rr_sel",   32'(rr_out_sel),   m_s[0]);
        chk("rr_ready", 32'(rr_in_ready),  32'(exp_rdy(0)));
        chk("fx_valid", 32'(fx_out_valid), 32'(m_v[1]));
        chk("fx_data",  fx_out_data,       m_d[1]);
        chk("fx_sel",   32'(fx_out_sel),   m_s[1]);
        chk("fx_ready", 32'(fx_in_ready),  32'(exp_rdy(1)));
        chk("n1_valid", 32'(n1_out_valid), 32'(m_v[2]));
        chk("n1_data",  n1_out_data,       m_d[2]);
        chk("n1_sel",   32'(n1_out_sel),   m_s[2]);
        chk("n1_ready", 32'(n1_in_ready),  32'(exp_rdy(2)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) in_data[i] = $urandom;
        in_valid  = 4'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rand_inputs();
        // Reset window with arbitrary inputs.
        repeat (3) begin
            step();
            rand_inputs();
            #1;
            chk("rst_in_ready", 32'(rr_in_ready), 32'h0);
            chk("rst_out_valid", 32'(rr_out_valid), 32'h0);
            chk("rst_out_data", rr_out_data, 32'h0);
        end

        // Release: first grant is the lowest valid channel.
        in_valid = 4'b0110; out_ready = 1'b1; rst_n = 1'b1;
        #1 chk("first_grant_rdy", 32'(rr_in_ready), 32'h2);
        step();
        chk("first_grant_sel", 32'(rr_out_sel), 32'd1);

        // Single channel transfer.
        in_valid = 4'b0100; in_data[2] = 32'hDEADBEEF;
        #1 chk("single_rdy", 32'(rr_in_ready), 32'h4);
        step();
        chk("single_valid", 32'(rr_out_valid), 32'd1);
        chk("single_data", rr_out_data, 32'hDEADBEEF);
        chk("single_sel", 32'(rr_out_sel), 32'd2);

        // Asynchronous reset while holding a word.
        rst_n = 1'b0;
        #1 chk("async_rst_valid", 32'(rr_out_valid), 32'd0);
        chk("async_rst_data", rr_out_data, 32'h0);
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i] = 32'h100 + i;
        step();
        rst_n = 1'b1;

        // Round-robin rotation from reset, one word per cycle.
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rot_sel", 32'(rr_out_sel), 32'(k % 4));
            chk("rot_data", rr_out_data, 32'h100 + 32'(k % 4));
            chk("rot_valid", 32'(rr_out_valid), 32'd1);
            chk("fix_all_sel", 32'(fx_out_sel), 32'd0);
        end

        // Fixed priority.
        in_valid = 4'b1010;
        repeat (3) begin
            step();
            chk("fix_sel1", 32'(fx_out_sel), 32'd1);
        end
        in_valid = 4'b1000;
        step();
        chk("fix_sel3", 32'(fx_out_sel), 32'd3);

        // Backpressure: RR ptr sits at 3, so channel 0 loads first.
        in_valid = 4'b0011;
        step();
        chk("bp_load_sel", 32'(rr_out_sel), 32'd0);
        out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_hold_sel", 32'(rr_out_sel), 32'd0);
            chk("bp_hold_data", rr_out_data, 32'h100);
            chk("bp_hold_rdy", 32'(rr_in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", 32'(rr_in_ready), 32'h2);
        step();
        chk("bp_next_sel", 32'(rr_out_sel), 32'd1);
        chk("bp_next_valid", 32'(rr_out_valid), 32'd1);

        // Randomised traffic with occasional reset pulses.
        repeat (3000) begin
            step();
            rand_inputs();
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
